// File: rtl/esteira_pkg.sv
// Shared encodings for the conveyor positioning controller.
package esteira_pkg;

    typedef enum logic [1:0] {
        POS_INICIO     = 2'b00,
        POS_ENCHIMENTO = 2'b01,
        POS_CQ         = 2'b10,
        POS_LACRE      = 2'b11
    } posicao_t;

    typedef enum logic [1:0] {
        INICIO  = 2'd0,
        PARADO  = 2'd1,
        MOVENDO = 2'd2
    } estado_t;

endpackage

// File: rtl/contador_percurso.sv
// Travel-time up-counter: synchronous clear, count enable, terminal-count flag.
module contador_percurso #(
    parameter int unsigned CICLOS_PERCURSO = 50000000,
    parameter int unsigned LARGURA_CONT    = 26
) (
    input  logic clk,
    input  logic Reset,
    input  logic limpa,
    input  logic habilita,
    output logic terminal
);

    logic [LARGURA_CONT-1:0] cont_q;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cont_q <= '0;
        end else if (limpa) begin
            cont_q <= '0;
        end else if (habilita) begin
            cont_q <= cont_q + LARGURA_CONT'(1);
        end
    end

    assign terminal = (cont_q == LARGURA_CONT'(CICLOS_PERCURSO - 1));

endmodule

// File: rtl/controle_esteira.sv
// Conveyor positioning controller: runs the belt one station per move request
// and reports the station where it has stopped.
module controle_esteira
    import esteira_pkg::*;
#(
    parameter int unsigned CICLOS_PERCURSO = 50000000,
    parameter int unsigned LARGURA_CONT    = 26
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Comando_Mover_Esteira,
    input  logic       Descarte,
    input  logic       Pausa,
    output logic       Motor_Ligado,
    output logic       Motor_Parado_Pos_Enchimento,
    output logic       Motor_Parado_Pos_CQ,
    output logic       Motor_Parado_Pos_Lacre,
    output logic       Pulso_Chegada,
    output logic [1:0] Posicao
);

    estado_t  estado_q;
    posicao_t posicao_q;
    posicao_t alvo_q;
    posicao_t alvo_d;
    logic     pulso_q;
    logic     inicia;
    logic     terminal;

    assign inicia = (estado_q != MOVENDO) && Comando_Mover_Esteira && !Pausa;

    always_comb begin
        alvo_d = POS_ENCHIMENTO;
        case (posicao_q)
            POS_ENCHIMENTO: alvo_d = POS_CQ;
            POS_CQ:         alvo_d = Descarte ? POS_ENCHIMENTO : POS_LACRE;
            default:        alvo_d = POS_ENCHIMENTO;
        endcase
    end

    contador_percurso #(
        .CICLOS_PERCURSO (CICLOS_PERCURSO),
        .LARGURA_CONT    (LARGURA_CONT)
    ) u_contador (
        .clk      (clk),
        .Reset    (Reset),
        .limpa    (inicia),
        .habilita ((estado_q == MOVENDO) && !Pausa),
        .terminal (terminal)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            estado_q  <= INICIO;
            posicao_q <= POS_INICIO;
            alvo_q    <= POS_ENCHIMENTO;
            pulso_q   <= 1'b0;
        end else begin
            pulso_q <= 1'b0;
            case (estado_q)
                INICIO, PARADO: begin
                    if (inicia) begin
                        estado_q <= MOVENDO;
                        alvo_q   <= alvo_d;
                    end
                end
                MOVENDO: begin
                    // Command is ignored here; only the counter ends travel.
                    if (!Pausa && terminal) begin
                        estado_q  <= PARADO;
                        posicao_q <= alvo_q;
                        pulso_q   <= 1'b1;
                    end
                end
                default: estado_q <= INICIO;
            endcase
        end
    end

    // Pause cuts the motor immediately, without waiting for a clock edge.
    assign Motor_Ligado  = (estado_q == MOVENDO) && !Pausa;
    assign Pulso_Chegada = pulso_q;
    assign Posicao       = posicao_q;

    assign Motor_Parado_Pos_Enchimento = (estado_q == PARADO) && (posicao_q == POS_ENCHIMENTO);
    assign Motor_Parado_Pos_CQ         = (estado_q == PARADO) && (posicao_q == POS_CQ);
    assign Motor_Parado_Pos_Lacre      = (estado_q == PARADO) && (posicao_q == POS_LACRE);

endmodule

// File: tb/tb_controle_esteira.sv
// Scoreboard bench for controle_esteira with a 4-cycle travel time.
module tb_controle_esteira;

    localparam int unsigned CICLOS = 4;

    logic       clk;
    logic       Reset;
    logic       Comando_Mover_Esteira;
    logic       Descarte;
    logic       Pausa;
    logic       Motor_Ligado;
    logic       Motor_Parado_Pos_Enchimento;
    logic       Motor_Parado_Pos_CQ;
    logic       Motor_Parado_Pos_Lacre;
    logic       Pulso_Chegada;
    logic [1:0] Posicao;

    controle_esteira #(
        .CICLOS_PERCURSO (CICLOS),
        .LARGURA_CONT    (4)
    ) dut (
        .clk                         (clk),
        .Reset                       (Reset),
        .Comando_Mover_Esteira       (Comando_Mover_Esteira),
        .Descarte                    (Descarte),
        .Pausa                       (Pausa),
        .Motor_Ligado                (Motor_Ligado),
        .Motor_Parado_Pos_Enchimento (Motor_Parado_Pos_Enchimento),
        .Motor_Parado_Pos_CQ         (Motor_Parado_Pos_CQ),
        .Motor_Parado_Pos_Lacre      (Motor_Parado_Pos_Lacre),
        .Pulso_Chegada               (Pulso_Chegada),
        .Posicao                     (Posicao)
    );

    typedef struct {
        logic [1:0] pos;
        int         ciclo;
    } chegada_t;

    chegada_t fila[$];
    int testes = 0;
    int falhas = 0;
    int ciclo  = 0;
    int motor_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic verifica(input string nome, input int obtido, input int esperado);
        testes++;
        if (obtido != esperado) begin
            falhas++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, obtido, esperado, $time);
        end
    endtask

    // {Enchimento, CQ, Lacre}
    function automatic int flags_de(input logic [1:0] pos);
        case (pos)
            2'b01:   return 4;
            2'b10:   return 2;
            2'b11:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int flags_dut();
        return {29'd0, Motor_Parado_Pos_Enchimento, Motor_Parado_Pos_CQ, Motor_Parado_Pos_Lacre};
    endfunction

    // Monitor: count motor-on cycles, check each arrival against the scoreboard.
    always @(negedge clk) begin
        if (Reset) begin
            motor_cnt = 0;
        end else begin
            if (Motor_Ligado) motor_cnt++;
            if (Pulso_Chegada) begin
                if (fila.size() == 0) begin
                    testes++;
                    falhas++;
                    $display("FAIL chegada_inesperada: got arrival at Posicao %0d expected none",
                             Posicao);
                end else begin
                    chegada_t e;
                    e = fila.pop_front();
                    verifica("chegada_posicao", int'(Posicao), int'(e.pos));
                    verifica("chegada_ciclo", ciclo, e.ciclo);
                    verifica("chegada_flags", flags_dut(), flags_de(e.pos));
                    verifica("chegada_motor_desligado", int'(Motor_Ligado), 0);
                    verifica("ciclos_motor", motor_cnt, CICLOS);
                end
                motor_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the command in the current cycle; the move begins next cycle.
    task automatic arranca(input logic desc, input logic [1:0] pos, input int dur,
                           input bit registra);
        chegada_t e;
        Comando_Mover_Esteira = 1'b1;
        Descarte = desc;
        e.pos   = pos;
        e.ciclo = ciclo + 1 + dur;
        if (registra) fila.push_back(e);
    endtask

    task automatic espera(input int hold);
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == hold) Comando_Mover_Esteira = 1'b0;
            if (Pulso_Chegada) return;
        end
        testes++;
        falhas++;
        $display("FAIL timeout_chegada: got no Pulso_Chegada expected one within 40 cycles");
        Comando_Mover_Esteira = 1'b0;
    endtask

    task automatic parado_em(input string nome, input logic [1:0] pos);
        tick();
        verifica({nome, "_flags"}, flags_dut(), flags_de(pos));
        verifica({nome, "_pulso"}, int'(Pulso_Chegada), 0);
        verifica({nome, "_motor"}, int'(Motor_Ligado), 0);
    endtask

    initial begin
        Reset = 1'b1;
        Comando_Mover_Esteira = 1'b1;
        Descarte = 1'b0;
        Pausa = 1'b0;
        tick();
        tick();
        verifica("reset_posicao", int'(Posicao), 0);
        verifica("reset_motor", int'(Motor_Ligado), 0);
        verifica("reset_flags", flags_dut(), 0);
        verifica("reset_pulso", int'(Pulso_Chegada), 0);

        // Command already high at reset release: first move to ENCHIMENTO.
        Reset = 1'b0;
        arranca(1'b0, 2'b01, 4, 1'b1);
        espera(2);
        parado_em("enchimento1", 2'b01);

        arranca(1'b0, 2'b10, 4, 1'b1);
        espera(1);
        parado_em("cq1", 2'b10);

        arranca(1'b1, 2'b01, 4, 1'b1);
        espera(1);
        parado_em("descarte", 2'b01);

        // Command held through travel must not trigger a second move.
        arranca(1'b0, 2'b10, 4, 1'b1);
        espera(4);
        parado_em("cq2", 2'b10);
        tick();
        verifica("sem_segundo_movimento", int'(Motor_Ligado), 0);

        arranca(1'b0, 2'b11, 4, 1'b1);
        espera(1);
        parado_em("lacre", 2'b11);

        // LACRE -> ENCHIMENTO, Descarte ignored, paused for 3 cycles after 2.
        arranca(1'b1, 2'b01, 7, 1'b1);
        tick();
        Comando_Mover_Esteira = 1'b0;
        tick();
        tick();
        Pausa = 1'b1;
        tick();
        verifica("pausa_motor", int'(Motor_Ligado), 0);
        verifica("pausa_flags", flags_dut(), 0);
        tick();
        tick();
        Pausa = 1'b0;
        espera(0);
        parado_em("enchimento_pausa", 2'b01);

        // Back-to-back: new command on the arrival-pulse cycle.
        arranca(1'b0, 2'b10, 4, 1'b1);
        espera(1);
        arranca(1'b0, 2'b11, 4, 1'b1);
        tick();
        Comando_Mover_Esteira = 1'b0;
        verifica("encadeado_motor", int'(Motor_Ligado), 1);
        verifica("encadeado_flags", flags_dut(), 0);
        espera(0);
        parado_em("lacre_encadeado", 2'b11);

        // Asynchronous reset on travel cycle 2.
        arranca(1'b0, 2'b01, 4, 1'b0);
        tick();
        Comando_Mover_Esteira = 1'b0;
        tick();
        #2;
        Reset = 1'b1;
        #1;
        verifica("reset_async_motor", int'(Motor_Ligado), 0);
        verifica("reset_async_posicao", int'(Posicao), 0);
        verifica("reset_async_flags", flags_dut(), 0);
        tick();
        Reset = 1'b0;
        tick();
        arranca(1'b0, 2'b01, 4, 1'b1);
        espera(1);
        parado_em("pos_reset", 2'b01);

        // Pause blocks move start while stopped.
        Pausa = 1'b1;
        Comando_Mover_Esteira = 1'b1;
        tick();
        tick();
        verifica("pausa_bloqueia_motor", int'(Motor_Ligado), 0);
        verifica("pausa_bloqueia_flags", flags_dut(), flags_de(2'b01));
        Comando_Mover_Esteira = 1'b0;
        Pausa = 1'b0;
        tick();
        tick();
        verifica("fila_vazia", fila.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule

// File: doc/controle_esteira.md
Name: controle_esteira

Overview:
- Conveyor positioning controller that sits directly downstream of the bottling process FSM.
- Consumes the FSM's move command (Comando_Mover_Esteira) and discard flag (LED_Descarte).
- Runs the belt motor for a fixed travel time between stations and reports where the belt has stopped.
- Produces the Motor_Parado_Pos_Enchimento, Motor_Parado_Pos_CQ and Motor_Parado_Pos_Lacre inputs that the FSM waits on.
- Station ring: ENCHIMENTO -> CQ -> LACRE -> ENCHIMENTO. A discard at CQ sends the belt straight to ENCHIMENTO.

Parameters:
- CICLOS_PERCURSO, 50000000: clock cycles the motor runs for one station-to-station move (1 s at 50 MHz); must be >= 1.
- LARGURA_CONT, 26: width of the travel counter; must satisfy 2^LARGURA_CONT > CICLOS_PERCURSO.

Ports:
- clk  input  1  system clock
- Reset  input  1  asynchronous, active-high reset
- Comando_Mover_Esteira  input  1  move request from the process FSM (level or single-cycle pulse)
- Descarte  input  1  connected to FSM LED_Descarte; sampled together with the move request
- Pausa  input  1  connected to alarme_rolha; freezes travel while high
- Motor_Ligado  output  1  belt motor drive
- Motor_Parado_Pos_Enchimento  output  1  belt stopped at the filling station
- Motor_Parado_Pos_CQ  output  1  belt stopped at the quality-control station
- Motor_Parado_Pos_Lacre  output  1  belt stopped at the sealing station
- Pulso_Chegada  output  1  one-cycle pulse on arrival at a station
- Posicao  output  2  current/last station: 00 INICIO, 01 ENCHIMENTO, 10 CQ, 11 LACRE

Behaviour:
- Clock and reset: clk; reset Reset, asynchronous, active-high.
- Reset values:
  - state INICIO, Posicao=00, counter=0, target=ENCHIMENTO.
  - Motor_Ligado, all Motor_Parado_Pos_* and Pulso_Chegada are 0.
- FSM states:
  - INICIO: stopped, no station.
  - PARADO: stopped at Posicao.
  - MOVENDO: travelling to the target station.
- Target selection, computed when a move starts:
  - from INICIO -> ENCHIMENTO
  - from ENCHIMENTO -> CQ
  - from CQ -> LACRE when Descarte=0, ENCHIMENTO when Descarte=1
  - from LACRE -> ENCHIMENTO
- Move start: in INICIO or PARADO, when Comando_Mover_Esteira=1 and Pausa=0 at a rising edge:
  - next cycle state=MOVENDO, counter=0, target latched.
  - Motor_Ligado=1 and all Motor_Parado_Pos_* = 0 from that cycle on.
- Comando_Mover_Esteira is ignored while in MOVENDO. This absorbs the FSM holding the command high during travel; no queueing.
- Travel: in MOVENDO with Pausa=0, counter increments by 1 per cycle.
- Arrival: in the cycle where counter==CICLOS_PERCURSO-1 and Pausa=0, the next edge gives:
  - state=PARADO, Posicao=target, Motor_Ligado=0, Pulso_Chegada=1 for exactly that one cycle.
  - Net effect: the motor is on for exactly CICLOS_PERCURSO unpaused cycles.
- Pause: Pausa=1 in MOVENDO holds the counter, forces Motor_Ligado=0 (combinational) and keeps all station flags 0. When Pausa falls, travel resumes with no lost or extra cycles.
- Pausa=1 in INICIO/PARADO blocks move start.
- Station flags are decoded from registers only: Motor_Parado_Pos_X = (state==PARADO && Posicao==X). This guarantees they are one-hot-or-zero and glitch-free.
- Move command on the first stopped cycle (the arrival-pulse cycle) is accepted; minimum dwell at a station is 1 cycle.
- Descarte is only meaningful at CQ; it is ignored at other stations and during travel.
- Reset mid-travel: immediate return to INICIO with motor off. The next move goes to ENCHIMENTO regardless of the prior position.
- CICLOS_PERCURSO=1: motor on for exactly one cycle per move.

Decomposition:
- Shared package esteira_pkg:
  - station encodings (POS_INICIO, POS_ENCHIMENTO, POS_CQ, POS_LACRE)
  - state encodings (INICIO, PARADO, MOVENDO)
- One sub-module, contador_percurso: parameterised up-counter with clear, enable (=!Pausa) and terminal-count output.
- Next-station logic stays inline as a small combinational case.

Test Plan:
- Bench uses CICLOS_PERCURSO=4 throughout.
- Reset release, Comando held high -> Motor_Ligado=1 for 4 cycles; Posicao goes 00->01; Pulso_Chegada one cycle; Motor_Parado_Pos_Enchimento=1 afterwards.
- At ENCHIMENTO, 1-cycle Comando pulse -> 4-cycle move; Posicao=10, Motor_Parado_Pos_CQ=1. Comando held high during travel causes no second move.
- At CQ, Comando with Descarte=1 -> arrives Posicao=01. Repeat with Descarte=0 -> Posicao=11; then Comando -> Posicao=01.
- Pausa=1 for 3 cycles after 2 travel cycles -> Motor_Ligado=0 during pause; arrival occurs 7 cycles after start; total motor-on cycles=4.
- Reset asserted on travel cycle 2 -> outputs cleared asynchronously, Posicao=00. Next Comando targets ENCHIMENTO.
- Comando asserted on the Pulso_Chegada cycle -> new move starts on the next cycle; station flag high for exactly 1 cycle.
